// File: rtl/fp_stream_converter.sv
// Converts a beat of LENGTH floating-point lanes between formats. Latency is 2 cycles.
// A full output register with out_ready low stalls the pipeline, and in_ready falls.
module fp_stream_converter #(
    parameter int LENGTH   = 4,
    parameter int IN_EXP   = 8,
    parameter int IN_MANT  = 23,
    parameter int OUT_EXP  = 5,
    parameter int OUT_MANT = 10
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [LENGTH*(1+IN_EXP+IN_MANT)-1:0]   data_in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [LENGTH*(1+OUT_EXP+OUT_MANT)-1:0] data_out,
    output logic [2:0]                             flags_out,
    input  logic                                   flags_clear,
    input  logic                                   debugen_in
);

    localparam int IW = 1 + IN_EXP + IN_MANT;
    localparam int OW = 1 + OUT_EXP + OUT_MANT;
    localparam int EW = ((IN_EXP > OUT_EXP) ? IN_EXP : OUT_EXP) + 2;
    localparam int BD = ((1 << (OUT_EXP - 1)) - 1) - ((1 << (IN_EXP - 1)) - 1);
    localparam logic signed [EW-1:0] BIAS_DELTA = EW'(BD);
    localparam logic signed [EW-1:0] EXP_MAX    = EW'((1 << OUT_EXP) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO   = '0;
    localparam logic [OUT_MANT-1:0]  QNAN_M     = OUT_MANT'(64'd1 << (OUT_MANT - 1));

    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_t;

    // Per-lane state carried from S1 to S2: rounded exponent/mantissa plus
    // the input class and the flags that are already known from the input alone.
    typedef struct packed {
        logic                   sign;
        cls_t                   cls;
        logic signed [EW-1:0]   exp;
        logic [OUT_MANT-1:0]    mant;
        logic                   inv;
        logic                   uf;
    } lane_t;

    localparam int LW = $bits(lane_t);

    logic                   s1_valid;
    logic [LENGTH*LW-1:0]   s1_d;
    logic [LENGTH*LW-1:0]   s1_q;
    logic [LENGTH*IW-1:0]   s1_din;
    logic [LENGTH*IW-1:0]   s2_din;
    logic [LENGTH*OW-1:0]   s2_d;
    logic [LENGTH-1:0]      inv_v;
    logic [LENGTH-1:0]      ov_v;
    logic [LENGTH-1:0]      uf_v;
    logic                   s2_adv;
    logic [2:0]             flag_set;

    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !reset && (!s1_valid || s2_adv);
    assign flag_set = {|inv_v, |ov_v, |uf_v};

    for (genvar g = 0; g < LENGTH; g++) begin : g_front
        logic [IW-1:0]          lane_in;
        logic [IN_EXP-1:0]      e_in;
        logic [IN_MANT-1:0]     m_in;
        logic signed [EW-1:0]   e_reb;
        logic [OUT_MANT-1:0]    m_rnd;
        logic                   carry;
        lane_t                  fe;

        assign lane_in = data_in[g*IW +: IW];
        assign e_in    = lane_in[IN_MANT +: IN_EXP];
        assign m_in    = lane_in[IN_MANT-1:0];
        assign e_reb   = $signed({{(EW-IN_EXP){1'b0}}, e_in}) + BIAS_DELTA;

        if (OUT_MANT >= IN_MANT) begin : g_widen
            assign m_rnd = OUT_MANT'(m_in) << (OUT_MANT - IN_MANT);
            assign carry = 1'b0;
        end else begin : g_round
            localparam int D = IN_MANT - OUT_MANT;
            logic [IN_MANT+1:0] mx;
            logic [OUT_MANT:0]  sum;
            logic               lsb, guard, rbit, sticky;

            // Two zero LSBs keep the round/sticky selects in range when D is 1.
            assign mx     = {m_in, 2'b00};
            assign lsb    = mx[D+2];
            assign guard  = mx[D+1];
            assign rbit   = mx[D];
            assign sticky = |mx[D-1:0];
            assign sum    = {1'b0, mx[IN_MANT+1 -: OUT_MANT]}
                          + {{OUT_MANT{1'b0}}, guard & (rbit | sticky | lsb)};
            assign m_rnd  = sum[OUT_MANT-1:0];
            assign carry  = sum[OUT_MANT];
        end

        always_comb begin
            fe      = '0;
            fe.sign = lane_in[IW-1];
            fe.exp  = e_reb + $signed({{(EW-1){1'b0}}, carry});
            fe.mant = m_rnd;
            if (e_in == '1) begin
                fe.cls = (m_in == '0) ? CLS_INF : CLS_NAN;
                fe.inv = (m_in != '0) && !m_in[IN_MANT-1];
            end else if (e_in == '0) begin
                fe.cls = CLS_ZERO;
                fe.uf  = (m_in != '0);
            end else begin
                fe.cls = CLS_NORM;
            end
        end

        assign s1_d[g*LW +: LW] = fe;
    end

    for (genvar g = 0; g < LENGTH; g++) begin : g_back
        lane_t                  q;
        logic signed [EW-1:0]   e;
        logic [OW-1:0]          o;
        logic                   fi, fo, fu;

        assign q = s1_q[g*LW +: LW];
        assign e = q.exp;

        always_comb begin
            o  = '0;
            fi = q.inv;
            fo = 1'b0;
            fu = q.uf;
            case (q.cls)
                CLS_NAN:  o = {q.sign, {OUT_EXP{1'b1}}, QNAN_M};
                CLS_INF:  o = {q.sign, {OUT_EXP{1'b1}}, {OUT_MANT{1'b0}}};
                CLS_ZERO: o = {q.sign, {(OW-1){1'b0}}};
                default: begin
                    if (e >= EXP_MAX) begin
                        o  = {q.sign, {OUT_EXP{1'b1}}, {OUT_MANT{1'b0}}};
                        fo = 1'b1;
                    end else if (e <= EXP_ZERO) begin
                        o  = {q.sign, {(OW-1){1'b0}}};
                        fu = 1'b1;
                    end else begin
                        o  = {q.sign, e[OUT_EXP-1:0], q.mant};
                    end
                end
            endcase
        end

        assign s2_d[g*OW +: OW] = o;
        assign inv_v[g]         = fi;
        assign ov_v[g]          = fo;
        assign uf_v[g]          = fu;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_q      <= '0;
            s1_din    <= '0;
            out_valid <= 1'b0;
            data_out  <= '0;
            s2_din    <= '0;
            flags_out <= 3'b000;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q   <= s1_d;
                    s1_din <= data_in;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    data_out <= s2_d;
                    s2_din   <= s1_din;
                end
            end
            // A flag raised by the beat entering data_out beats a simultaneous clear.
            flags_out <= (flags_clear ? 3'b000 : flags_out)
                       | ((s2_adv && s1_valid) ? flag_set : 3'b000);
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && debugen_in && out_valid && out_ready)
            $write("fp_stream_converter: in=%h out=%h\n", s2_din, data_out);
    end
`endif

endmodule

// File: tb/tb_fp_stream_converter.sv
// Directed bench: FP32->FP16 vectors, backpressure stream, flag and reset corners, FP16->FP32 widening.
module tb_fp_stream_converter;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] data_in;
    logic [63:0]  data_out;
    logic [2:0]   flags_out;
    logic         flags_clear, debugen_in;

    logic         w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [15:0]  w_data_in;
    logic [31:0]  w_data_out;
    logic [2:0]   w_flags_out;
    logic         w_flags_clear;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp_stream_converter u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .flags_out(flags_out), .flags_clear(flags_clear),
        .debugen_in(debugen_in)
    );

    fp_stream_converter #(
        .LENGTH(1), .IN_EXP(5), .IN_MANT(10), .OUT_EXP(8), .OUT_MANT(23)
    ) u_wide (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .data_in(w_data_in), .out_valid(w_out_valid), .out_ready(w_out_ready),
        .data_out(w_data_out), .flags_out(w_flags_out), .flags_clear(w_flags_clear),
        .debugen_in(1'b0)
    );

    typedef struct {
        logic [127:0] din;
        logic [63:0]  dout;
        logic [2:0]   flg;
    } vec_t;

    typedef struct {
        logic [15:0] din;
        logic [31:0] dout;
        logic [2:0]  flg;
    } wvec_t;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] mk_in(input int i);
        logic [127:0] v = '0;
        for (int l = 0; l < 4; l++)
            v[l*32 +: 32] = {(l % 2 == 1), 8'(127 + i + l), 23'(i << 13)};
        return v;
    endfunction

    function automatic logic [63:0] mk_out(input int i);
        logic [63:0] v = '0;
        for (int l = 0; l < 4; l++)
            v[l*16 +: 16] = {(l % 2 == 1), 5'(15 + i + l), 10'(i)};
        return v;
    endfunction

    task automatic run_vec(input int idx, input logic [127:0] din,
                           input logic [63:0] dout, input logic [2:0] flg);
        string tag;
        tag = $sformatf("vec%0d", idx);
        in_valid = 1'b1;
        data_in  = din;
        step;
        in_valid = 1'b0;
        step;
        chk({tag, "_latency_valid"}, out_valid, 1'b1);
        chk({tag, "_data"}, data_out, dout);
        chk({tag, "_flags"}, flags_out, flg);
        flags_clear = 1'b1;
        step;
        flags_clear = 1'b0;
        chk({tag, "_clear"}, flags_out, 3'b000);
        chk({tag, "_drained"}, out_valid, 1'b0);
    endtask

    task automatic run_wide(input int idx, input logic [15:0] din,
                            input logic [31:0] dout, input logic [2:0] flg);
        string tag;
        tag = $sformatf("wide%0d", idx);
        w_in_valid = 1'b1;
        w_data_in  = din;
        step;
        w_in_valid = 1'b0;
        step;
        chk({tag, "_valid"}, w_out_valid, 1'b1);
        chk({tag, "_data"}, w_data_out, dout);
        chk({tag, "_flags"}, w_flags_out, flg);
        w_flags_clear = 1'b1;
        step;
        w_flags_clear = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t         vt [8];
        wvec_t        wt [6];
        int           pat [4];
        int           sent, rx;
        logic         prev_stall, fire_in;
        logic [63:0]  prev_dout;

        vt[0] = '{{32'h40490FDB, 32'h00000000, 32'hBF800000, 32'h3F800000},
                  {16'h4248, 16'h0000, 16'hBC00, 16'h3C00}, 3'b000};
        vt[1] = '{{32'h80000000, 32'h477FE000, 32'h3F803000, 32'h3F801000},
                  {16'h8000, 16'h7BFF, 16'h3C02, 16'h3C00}, 3'b000};
        vt[2] = '{{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h477FF000},
                  {16'h3C00, 16'h3C00, 16'h3C00, 16'h7C00}, 3'b010};
        vt[3] = '{{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h33000000},
                  {16'h3C00, 16'h3C00, 16'h3C00, 16'h0000}, 3'b001};
        vt[4] = '{{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F800001},
                  {16'h3C00, 16'h3C00, 16'h3C00, 16'h7E00}, 3'b100};
        vt[5] = '{{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'hFFC00000},
                  {16'h3C00, 16'h3C00, 16'h3C00, 16'hFE00}, 3'b000};
        vt[6] = '{{32'hC0000000, 32'h7F800000, 32'h00400000, 32'hFF800000},
                  {16'hC000, 16'h7C00, 16'h0000, 16'hFC00}, 3'b001};
        vt[7] = '{{32'h38800000, 32'h7FC00000, 32'h80400000, 32'hC77FF000},
                  {16'h0400, 16'h7E00, 16'h8000, 16'hFC00}, 3'b011};

        wt[0] = '{16'h3C00, 32'h3F800000, 3'b000};
        wt[1] = '{16'h7C00, 32'h7F800000, 3'b000};
        wt[2] = '{16'h0001, 32'h00000000, 3'b001};
        wt[3] = '{16'hC000, 32'hC0000000, 3'b000};
        wt[4] = '{16'hFE00, 32'hFFC00000, 3'b000};
        wt[5] = '{16'h7D00, 32'h7FC00000, 3'b100};

        pat = '{1, 0, 0, 1};

        reset         = 1'b1;
        in_valid      = 1'b0;
        data_in       = '0;
        out_ready     = 1'b1;
        flags_clear   = 1'b0;
        debugen_in    = 1'b0;
        w_in_valid    = 1'b0;
        w_data_in     = '0;
        w_out_ready   = 1'b1;
        w_flags_clear = 1'b0;

        step;
        step;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flags", flags_out, 3'b000);
        chk("rst_data_out", data_out, 64'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        step;

        for (int i = 0; i < 8; i++) begin
            debugen_in = (i == 0);
            run_vec(i, vt[i].din, vt[i].dout, vt[i].flg);
        end
        debugen_in = 1'b0;

        // Overflow beat reaching data_out while flags_clear is held high.
        flags_clear = 1'b1;
        in_valid    = 1'b1;
        data_in     = vt[2].din;
        step;
        in_valid    = 1'b0;
        step;
        flags_clear = 1'b0;
        chk("flag_set_wins", flags_out, 3'b010);
        step;
        chk("flag_sticky", flags_out, 3'b010);
        flags_clear = 1'b1;
        step;
        flags_clear = 1'b0;
        chk("flag_clear_alone", flags_out, 3'b000);

        // Eight-beat stream with out_ready cycling 1,0,0,1.
        sent       = 0;
        rx         = 0;
        prev_stall = 1'b0;
        prev_dout  = '0;
        for (int c = 0; c < 200 && rx < 8; c++) begin
            out_ready = (pat[c % 4] != 0);
            in_valid  = (sent < 8);
            data_in   = mk_in(sent);
            #1;
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", data_out, prev_dout);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_beat%0d", rx), data_out, mk_out(rx));
                rx++;
            end
            prev_stall = out_valid && !out_ready;
            prev_dout  = data_out;
            fire_in    = in_valid && in_ready;
            step;
            if (fire_in) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", rx, 8);
        chk("bp_sent", sent, 8);
        chk("bp_no_dup", out_valid, 1'b0);
        step;
        chk("bp_no_dup2", out_valid, 1'b0);

        // Reset with a beat in flight discards it.
        in_valid = 1'b1;
        data_in  = vt[0].din;
        step;
        in_valid = 1'b0;
        reset    = 1'b1;
        step;
        reset    = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        step;
        step;
        chk("midrst_discard", out_valid, 1'b0);

        for (int i = 0; i < 6; i++)
            run_wide(i, wt[i].din, wt[i].dout, wt[i].flg);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
